// File: rtl/axi_slave_shim.sv
// AXI4 subordinate shim: turns AW/W/AR bursts into single-beat accesses on a
// 64-bit SRAM-style port, one transaction in flight, one registered R beat.
package ariane_axi;
    localparam int unsigned IdWidth = 4;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [63:0]        addr;
        logic [7:0]         len;
        logic [2:0]         size;
        logic [1:0]         burst;
        logic [5:0]         atop;
    } aw_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [63:0]        addr;
        logic [7:0]         len;
        logic [2:0]         size;
        logic [1:0]         burst;
    } ar_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [1:0]         resp;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [63:0]        data;
        logic [1:0]         resp;
        logic               last;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;
endpackage

module axi_slave_shim #(
    parameter int unsigned AxiNumWords = 4,
    parameter int unsigned AxiIdWidth  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  ariane_axi::req_t  axi_req_i,
    output ariane_axi::resp_t axi_resp_o,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic              mem_we_o,
    output logic [63:0]       mem_addr_o,
    output logic [63:0]       mem_wdata_o,
    output logic [7:0]        mem_be_o,
    input  logic              mem_rvalid_i,
    input  logic [63:0]       mem_rdata_i
);
    localparam logic [7:0] MaxLen = 8'(AxiNumWords - 1);

    typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_REQ, RD_WAIT, RD_DATA} state_e;

    state_e                state_q;
    logic [AxiIdWidth-1:0] id_q;
    logic [63:0]           addr_q, rdata_q, next_addr;
    logic [7:0]            len_q, cnt_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic                  err_q, drop_q, rr_q;
    logic                  aw_hs, ar_hs, w_hs, last_beat;

    // rr_q=1 hands the next AW/AR tie to the read side
    assign aw_hs = (state_q == IDLE) & axi_req_i.aw_valid & (~axi_req_i.ar_valid | ~rr_q);
    assign ar_hs = (state_q == IDLE) & axi_req_i.ar_valid & (~axi_req_i.aw_valid | rr_q);
    assign w_hs  = (state_q == WR_DATA) & axi_req_i.w_valid & (drop_q | mem_gnt_i);
    assign last_beat = (cnt_q == len_q);
    assign next_addr = (burst_q == 2'b01 || burst_q == 2'b10) ? addr_q + (64'd1 << size_q) : addr_q;

    // drop_q: burst rejected at capture, never touches memory; err_q: reported as SLVERR
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (aw_hs) begin
                        id_q    <= axi_req_i.aw.id;
                        addr_q  <= axi_req_i.aw.addr;
                        len_q   <= axi_req_i.aw.len;
                        size_q  <= axi_req_i.aw.size;
                        burst_q <= axi_req_i.aw.burst;
                        cnt_q   <= '0;
                        err_q   <= (axi_req_i.aw.len > MaxLen) | (axi_req_i.aw.atop != '0);
                        drop_q  <= (axi_req_i.aw.len > MaxLen) | (axi_req_i.aw.atop != '0);
                        if (axi_req_i.ar_valid) rr_q <= 1'b1;
                        state_q <= WR_DATA;
                    end else if (ar_hs) begin
                        id_q    <= axi_req_i.ar.id;
                        addr_q  <= axi_req_i.ar.addr;
                        len_q   <= axi_req_i.ar.len;
                        size_q  <= axi_req_i.ar.size;
                        burst_q <= axi_req_i.ar.burst;
                        cnt_q   <= '0;
                        err_q   <= (axi_req_i.ar.len > MaxLen);
                        drop_q  <= (axi_req_i.ar.len > MaxLen);
                        if (axi_req_i.aw_valid) rr_q <= 1'b0;
                        state_q <= RD_REQ;
                    end
                end
                WR_DATA: if (w_hs) begin
                    cnt_q  <= cnt_q + 8'd1;
                    addr_q <= next_addr;
                    if (axi_req_i.w.last != last_beat) err_q <= 1'b1;
                    if (last_beat) state_q <= WR_RESP;
                end
                WR_RESP: if (axi_req_i.b_ready) state_q <= IDLE;
                RD_REQ: begin
                    if (drop_q) begin
                        rdata_q <= '0;
                        state_q <= RD_DATA;
                    end else if (mem_gnt_i) begin
                        state_q <= RD_WAIT;
                    end
                end
                RD_WAIT: if (mem_rvalid_i) begin
                    rdata_q <= mem_rdata_i;
                    state_q <= RD_DATA;
                end
                RD_DATA: if (axi_req_i.r_ready) begin
                    if (last_beat) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q   <= cnt_q + 8'd1;
                        addr_q  <= next_addr;
                        state_q <= RD_REQ;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.aw_ready = aw_hs;
        axi_resp_o.ar_ready = ar_hs;
        axi_resp_o.w_ready  = w_hs;
        axi_resp_o.b_valid  = (state_q == WR_RESP);
        axi_resp_o.b.id     = id_q;
        axi_resp_o.b.resp   = err_q ? 2'b10 : 2'b00;
        axi_resp_o.r_valid  = (state_q == RD_DATA);
        axi_resp_o.r.id     = id_q;
        axi_resp_o.r.data   = rdata_q;
        axi_resp_o.r.resp   = err_q ? 2'b10 : 2'b00;
        axi_resp_o.r.last   = (state_q == RD_DATA) & last_beat;
    end

    assign mem_req_o   = ~drop_q & (((state_q == WR_DATA) & axi_req_i.w_valid) | (state_q == RD_REQ));
    assign mem_we_o    = (state_q == WR_DATA);
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = (state_q == WR_DATA) ? axi_req_i.w.data : 64'd0;
    assign mem_be_o    = (state_q == WR_DATA) ? axi_req_i.w.strb :
                         (state_q == RD_REQ)  ? 8'hFF : 8'h00;
endmodule
